// File: rtl/ex_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_ctrl
// Brief    : EX-stage multi-cycle DIV/DIVU sequencer (restoring, 1 bit/cycle)
// Revision : 1.0 - initial release
// ============================================================================

module ex_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               stallreq_o
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             quot_neg;
  logic             rem_neg;

  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quot_nxt;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // The quotient register doubles as the dividend shifter: dividend MSBs
  // leave at the top while quotient bits enter at the bottom.
  always_comb begin
    sign1    = signed_div_i & opdata1_i[WIDTH-1];
    sign2    = signed_div_i & opdata2_i[WIDTH-1];
    abs1     = sign1 ? -opdata1_i : opdata1_i;
    abs2     = sign2 ? -opdata2_i : opdata2_i;
    shifted  = {rem, quot[WIDTH-1]};
    take     = (shifted >= {1'b0, divisor});
    // The kept difference is always below the divisor, so it fits WIDTH bits.
    rem_nxt  = take ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    quot_nxt = {quot[WIDTH-2:0], take};
    quot_fix = quot_neg ? -quot_nxt : quot_nxt;
    rem_fix  = rem_neg ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      count    <= '0;
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= ZERO;
            end else begin
              quot     <= abs1;
              divisor  <= abs2;
              rem      <= '0;
              quot_neg <= sign1 ^ sign2;
              rem_neg  <= sign1;
              count    <= '0;
              state    <= BUSY;
            end
          end
        end
        ZERO: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            result_o <= '0;
            state    <= DONE;
          end
        end
        BUSY: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            quot  <= quot_nxt;
            rem   <= rem_nxt;
            count <= count + CW'(1);
            if (count == LAST) begin
              result_o <= {rem_fix, quot_fix};
              state    <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state != IDLE);
  assign ready_o    = (state == DONE);
  assign stallreq_o = start_i & ~ready_o;

endmodule

`default_nettype wire

// File: tb/tb_ex_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_div_ctrl
// Brief    : directed self-checking bench for ex_div_ctrl
// Revision : 1.0 - initial release
// ============================================================================

module tb_ex_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        stallreq_o;

  int errors = 0;
  int checks = 0;

  ex_div_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds start_i until the ready cycle, counting stall cycles before it.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic [63:0] res, output bit got);
    @(negedge clk);
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    cycles       = 0;
    got          = 1'b0;
    res          = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (ready_o) begin
        got = 1'b1;
        res = result_o;
        check("stall_low_in_ready", {63'd0, stallreq_o}, 64'd0);
      end else begin
        if (stallreq_o) cycles++;
        @(negedge clk);
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("ready_single_pulse", {63'd0, ready_o}, 64'd0);
  endtask

  int          cyc;
  logic [63:0] res;
  bit          got;
  bit          seen;
  int          n, n1, n2;
  logic [63:0] r1, r2;

  initial begin
    resetn       = 1'b0;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_stall", {63'd0, stallreq_o}, 64'd0);
    resetn = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, cyc, res, got);
    check("divu100_7_got", {63'd0, got}, 64'd1);
    check("divu100_7_cycles", 64'(cyc), 64'd33);
    check("divu100_7_result", res, {32'd2, 32'd14});

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, cyc, res, got);
    check("div_m7_2_result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("div_m7_2_cycles", 64'(cyc), 64'd33);

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc, res, got);
    check("div_ovf_result", res, {32'h0, 32'h8000_0000});

    // Annul in BUSY cycle 10: result must keep {0, 0x80000000}.
    @(negedge clk);
    start_i   = 1'b1;
    opdata1_i = 32'hFFFF_FFFF;
    opdata2_i = 32'd3;
    signed_div_i = 1'b0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    #1;
    check("busy_mid_op", {63'd0, busy_o}, 64'd1);
    check("stall_mid_op", {63'd0, stallreq_o}, 64'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    #1;
    check("annul_busy", {63'd0, busy_o}, 64'd0);
    check("annul_result_kept", result_o, {32'h0, 32'h8000_0000});
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check("annul_no_ready", {63'd0, seen}, 64'd0);

    // Async reset in BUSY cycle 20, checked before the next rising edge.
    @(negedge clk);
    start_i   = 1'b1;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    @(negedge clk);
    repeat (20) @(negedge clk);
    #2;
    resetn  = 1'b0;
    start_i = 1'b0;
    #1;
    check("arst_result", result_o, 64'd0);
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_ready", {63'd0, ready_o}, 64'd0);
    check("arst_stall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_div(1'b0, 32'd9, 32'd3, cyc, res, got);
    check("divu9_3_result", res, {32'd0, 32'd3});
    check("divu9_3_cycles", 64'(cyc), 64'd33);

    run_div(1'b0, 32'd5, 32'd0, cyc, res, got);
    check("divu5_0_got", {63'd0, got}, 64'd1);
    check("divu5_0_cycles", 64'(cyc), 64'd2);
    check("divu5_0_result", res, 64'd0);

    // Back-to-back with start_i held; operand noise while BUSY.
    @(negedge clk);
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd10;
    n  = 0;
    n1 = -1;
    n2 = -1;
    r1 = '0;
    r2 = '0;
    while (n2 < 0 && n < 200) begin
      #1;
      if (ready_o) begin
        if (n1 < 0) begin
          n1 = n;
          r1 = result_o;
          opdata1_i = 32'd7;
          opdata2_i = 32'd7;
        end else if (n2 < 0) begin
          n2 = n;
          r2 = result_o;
        end
      end
      if (n1 < 0 && n == 5) begin
        opdata1_i = 32'd123;
        opdata2_i = 32'd0;
      end
      if (n1 >= 0 && n == n1 + 10) begin
        opdata1_i = 32'd40;
        opdata2_i = 32'd0;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    check("b2b_first_result", r1, {32'd0, 32'd100});
    check("b2b_second_result", r2, {32'd0, 32'd1});
    check("b2b_spacing", 64'(n2 - n1), 64'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
